// File: rtl/xnormaj_act_packer.sv
// Packs single-bit XNOR-majority results into M-bit activation words, LSB first,
// with partial-word flush on in_last and a valid/ready output register.
module xnormaj_act_packer #(
  parameter int M  = 9,
  parameter int FW = $clog2(M + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_m,
  input  logic          in_last,
  output logic          in_ready,
  output logic          out_valid,
  output logic [M-1:0]  out_a,
  output logic [FW-1:0] out_fill,
  output logic          out_last,
  input  logic          out_ready
);

  // Handshake: a beat moves when in_valid && in_ready; a word moves when
  // out_valid && out_ready. in_ready never looks at in_valid.

  logic [M-1:0]  acc;
  logic [M-1:0]  word;
  logic [FW-1:0] cnt;
  logic          accept;
  logic          complete;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign complete = accept && (in_last || (cnt == FW'(M - 1)));

  // Accumulator with the incoming bit merged at cnt; bits above cnt read as 0
  // so a flushed partial word is always zero-padded.
  always_comb begin
    word = '0;
    for (int i = 0; i < M; i++) begin
      if (FW'(i) < cnt) begin
        word[i] = acc[i];
      end else if (FW'(i) == cnt) begin
        word[i] = in_m;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (complete) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= word;
        cnt <= cnt + FW'(1);
      end
    end
  end

  // A completing accept always wins over a plain transfer, so a word taken in
  // the same cycle is replaced without a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_fill  <= '0;
      out_last  <= 1'b0;
    end else if (complete) begin
      out_valid <= 1'b1;
      out_a     <= word;
      out_fill  <= cnt + FW'(1);
      out_last  <= in_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xnormaj_act_packer.sv
// Bench for xnormaj_act_packer: directed scenarios plus a randomized soak,
// with M=9 and M=1 instances checked against a bit-queue reference model.
module tb_xnormaj_act_packer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       iv = 1'b0, im = 1'b0, il = 1'b0, ordy = 1'b0;
  logic       ir, ov, ol;
  logic [8:0] oa;
  logic [3:0] of;

  logic       iv1 = 1'b0, im1 = 1'b0, il1 = 1'b0, ordy1 = 1'b0;
  logic       ir1, ov1, ol1;
  logic [0:0] oa1;
  logic [0:0] of1;

  xnormaj_act_packer #(.M(9)) dut9 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_m(im), .in_last(il), .in_ready(ir),
    .out_valid(ov), .out_a(oa), .out_fill(of), .out_last(ol), .out_ready(ordy)
  );

  xnormaj_act_packer #(.M(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_m(im1), .in_last(il1), .in_ready(ir1),
    .out_valid(ov1), .out_a(oa1), .out_fill(of1), .out_last(ol1), .out_ready(ordy1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: bits of the word being built, and completed words
  // awaiting transfer, packed as {last, fill[3:0], a[8:0]}.
  bit          pend9[$];
  bit          pend1[$];
  logic [13:0] exp_q9[$];
  logic [13:0] exp_q1[$];

  logic        o_ready, o_valid, o_last;
  logic [8:0]  o_a;
  logic [3:0]  o_fill;
  logic        e_ready, e_valid;
  logic [13:0] e_word;
  bit          took;

  task automatic clear_model();
    pend9.delete();
    pend1.delete();
    exp_q9.delete();
    exp_q1.delete();
  endtask

  // One clock: drive at the falling edge, sample 1 ns later, advance the model.
  task automatic step(input int d, input bit v, input bit m, input bit l, input bit r);
    logic [13:0] w;
    int          n;
    int          mw;
    @(negedge clk);
    if (d == 0) begin
      iv = v; im = m; il = l; ordy = r;
    end else begin
      iv1 = v; im1 = m; il1 = l; ordy1 = r;
    end
    #1;
    if (d == 0) begin
      o_ready = ir; o_valid = ov; o_a = oa; o_fill = of; o_last = ol;
    end else begin
      o_ready = ir1; o_valid = ov1; o_a = {8'd0, oa1}; o_fill = {3'd0, of1}; o_last = ol1;
    end
    mw      = (d == 0) ? 9 : 1;
    e_valid = (d == 0) ? (exp_q9.size() != 0) : (exp_q1.size() != 0);
    e_word  = '0;
    if (e_valid) e_word = (d == 0) ? exp_q9[0] : exp_q1[0];
    e_ready = !e_valid || r;
    took    = v && e_ready;
    if (e_valid && r) begin
      if (d == 0) exp_q9.delete(0);
      else exp_q1.delete(0);
    end
    if (took) begin
      if (d == 0) pend9.push_back(m);
      else pend1.push_back(m);
      n = (d == 0) ? pend9.size() : pend1.size();
      if (n == mw || l) begin
        w = '0;
        for (int i = 0; i < n; i++) w[i] = (d == 0) ? pend9[i] : pend1[i];
        w[12:9] = 4'(n);
        w[13]   = l;
        if (d == 0) begin
          exp_q9.push_back(w);
          pend9.delete();
        end else begin
          exp_q1.push_back(w);
          pend1.delete();
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    iv = 0; im = 0; il = 0; ordy = 0;
    iv1 = 0; im1 = 0; il1 = 0; ordy1 = 0;
    clear_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (ov !== 1'b0) $display("FAIL reset_valid: got %b want 0", ov); else n_pass++;
    n_checks++; if (oa !== 9'h000) $display("FAIL reset_a: got %h want 000", oa); else n_pass++;
    n_checks++; if (of !== 4'd0) $display("FAIL reset_fill: got %0d want 0", of); else n_pass++;
    n_checks++; if (ol !== 1'b0) $display("FAIL reset_last: got %b want 0", ol); else n_pass++;
    n_checks++; if (ir !== 1'b1) $display("FAIL reset_ready: got %b want 1", ir); else n_pass++;
    n_checks++; if (ir1 !== 1'b1 || ov1 !== 1'b0) $display("FAIL reset_m1: ready %b valid %b want 1 0", ir1, ov1); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    // Leave a word pending under backpressure, then reset between edges.
    step(0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0);
    n_checks++; if (o_valid !== 1'b1) $display("FAIL pre_async_valid: got %b want 1", o_valid); else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_checks++; if (ov !== 1'b0) $display("FAIL async_reset_valid: got %b want 0", ov); else n_pass++;
    n_checks++; if (oa !== 9'h000 || of !== 4'd0) $display("FAIL async_reset_word: a %h fill %0d want 000 0", oa, of); else n_pass++;
    n_checks++; if (ir !== 1'b1) $display("FAIL async_reset_ready: got %b want 1", ir); else n_pass++;
    do_reset();
  endtask

  task automatic test_stream();
    logic [17:0] sb;
    sb = {9'h0B2, 9'h14D};
    do_reset();
    for (int k = 0; k < 18; k++) begin
      step(0, 1, sb[k], 0, 1);
      n_checks++; if (o_ready !== 1'b1) $display("FAIL stream_ready k=%0d: got %b want 1", k, o_ready); else n_pass++;
      n_checks++; if (o_valid !== 1'(k == 9)) $display("FAIL stream_valid k=%0d: got %b want %b", k, o_valid, k == 9); else n_pass++;
      if (k == 9) begin
        n_checks++; if (o_a !== 9'h14D || o_fill !== 4'd9 || o_last !== 1'b0)
          $display("FAIL stream_word1: a %h fill %0d last %b want 14d 9 0", o_a, o_fill, o_last); else n_pass++;
      end
    end
    step(0, 0, 0, 0, 1);
    n_checks++; if (o_valid !== 1'b1 || o_a !== 9'h0B2 || o_fill !== 4'd9 || o_last !== 1'b0)
      $display("FAIL stream_word2: v %b a %h fill %0d last %b want 1 0b2 9 0", o_valid, o_a, o_fill, o_last); else n_pass++;
    step(0, 0, 0, 0, 1);
    n_checks++; if (o_valid !== 1'b0) $display("FAIL stream_drain: got %b want 0", o_valid); else n_pass++;
  endtask

  task automatic test_partial();
    logic [3:0] pb;
    pb = 4'b1011;
    do_reset();
    for (int k = 0; k < 4; k++) step(0, 1, pb[k], k == 3, 1);
    step(0, 1, 1, 1, 1);
    n_checks++; if (o_valid !== 1'b1 || o_a !== 9'h00B || o_fill !== 4'd4 || o_last !== 1'b1)
      $display("FAIL partial_word: v %b a %h fill %0d last %b want 1 00b 4 1", o_valid, o_a, o_fill, o_last); else n_pass++;
    step(0, 0, 0, 0, 1);
    n_checks++; if (o_valid !== 1'b1 || o_a !== 9'h001 || o_fill !== 4'd1 || o_last !== 1'b1)
      $display("FAIL partial_next_bit0: v %b a %h fill %0d last %b want 1 001 1 1", o_valid, o_a, o_fill, o_last); else n_pass++;
    n_checks++; if (o_a !== e_word[8:0]) $display("FAIL partial_model: got %h want %h", o_a, e_word[8:0]); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [26:0] bp;
    logic [8:0]  recv[$];
    logic [8:0]  held_a;
    logic [3:0]  held_fill;
    logic        held_last;
    int          idx, cyc, stall;
    bit          first_done, r;
    bp = 27'($urandom);
    idx = 0; cyc = 0; stall = 0; first_done = 0;
    held_a = '0; held_fill = '0; held_last = 1'b0;
    do_reset();
    while (idx < 27 && cyc < 200) begin
      r = !(first_done && stall < 5);
      step(0, 1, bp[idx], 0, r);
      n_checks++; if (o_ready !== e_ready) $display("FAIL bp_ready cyc=%0d: got %b want %b", cyc, o_ready, e_ready); else n_pass++;
      n_checks++; if (o_valid !== e_valid) $display("FAIL bp_valid cyc=%0d: got %b want %b", cyc, o_valid, e_valid); else n_pass++;
      if (o_valid && r) recv.push_back(o_a);
      if (first_done && stall < 5) begin
        if (stall == 0) begin
          held_a = o_a; held_fill = o_fill; held_last = o_last;
          n_checks++; if (held_a !== bp[8:0] || held_fill !== 4'd9)
            $display("FAIL bp_first_word: a %h fill %0d want %h 9", held_a, held_fill, bp[8:0]); else n_pass++;
        end
        n_checks++; if (o_ready !== 1'b0) $display("FAIL bp_stall_ready s=%0d: got %b want 0", stall, o_ready); else n_pass++;
        n_checks++; if (o_a !== held_a || o_fill !== held_fill || o_last !== held_last)
          $display("FAIL bp_stable s=%0d: a %h fill %0d last %b want %h %0d %b", stall, o_a, o_fill, o_last, held_a, held_fill, held_last); else n_pass++;
        stall++;
      end
      if (took) idx++;
      if (idx == 9) first_done = 1;
      cyc++;
    end
    n_checks++; if (cyc >= 200) $display("FAIL bp_timeout: accepted %0d want 27", idx); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 1);
      if (o_valid) recv.push_back(o_a);
    end
    n_checks++; if (recv.size() != 3) $display("FAIL bp_word_count: got %0d want 3", recv.size()); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      if (k < recv.size()) begin
        n_checks++; if (recv[k] !== bp[9*k +: 9]) $display("FAIL bp_scoreboard w%0d: got %h want %h", k, recv[k], bp[9*k +: 9]); else n_pass++;
      end
    end
  endtask

  task automatic test_edge();
    do_reset();
    for (int k = 0; k < 9; k++) step(0, 1, k % 2 == 0, k == 8, 1);
    step(0, 0, 0, 0, 1);
    n_checks++; if (o_valid !== 1'b1 || o_a !== 9'h155 || o_fill !== 4'd9 || o_last !== 1'b1)
      $display("FAIL edge_last_full: v %b a %h fill %0d last %b want 1 155 9 1", o_valid, o_a, o_fill, o_last); else n_pass++;
    step(0, 0, 0, 0, 1);
    n_checks++; if (o_valid !== 1'b0) $display("FAIL edge_no_empty_word: got %b want 0", o_valid); else n_pass++;
    for (int k = 0; k < 3; k++) step(0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 1);
    n_checks++; if (o_valid !== 1'b0) $display("FAIL edge_last_no_valid: got %b want 0", o_valid); else n_pass++;
    step(1, 1, 1, 0, 1);
    step(1, 1, 0, 0, 1);
    n_checks++; if (o_valid !== 1'b1 || o_a !== 9'h001 || o_fill !== 4'd1)
      $display("FAIL m1_word1: v %b a %h fill %0d want 1 1 1", o_valid, o_a, o_fill); else n_pass++;
    step(1, 0, 0, 0, 1);
    n_checks++; if (o_valid !== 1'b1 || o_a !== 9'h000 || o_fill !== 4'd1)
      $display("FAIL m1_word2: v %b a %h fill %0d want 1 0 1", o_valid, o_a, o_fill); else n_pass++;
    step(1, 0, 0, 0, 1);
    n_checks++; if (o_valid !== 1'b0) $display("FAIL m1_drain: got %b want 0", o_valid); else n_pass++;
  endtask

  task automatic test_soak(input int d);
    bit         v, m, l, r;
    bit         prev_stall;
    logic [8:0] prev_a;
    logic [3:0] prev_fill;
    logic       prev_last;
    prev_stall = 0; prev_a = '0; prev_fill = '0; prev_last = 1'b0;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      v = ($urandom_range(0, 3) != 0);
      m = 1'($urandom_range(0, 1));
      l = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 3) != 0);
      step(d, v, m, l, r);
      n_checks++; if (o_ready !== e_ready) $display("FAIL soak%0d_ready c=%0d: got %b want %b", d, c, o_ready, e_ready); else n_pass++;
      n_checks++; if (o_valid !== e_valid) $display("FAIL soak%0d_valid c=%0d: got %b want %b", d, c, o_valid, e_valid); else n_pass++;
      if (e_valid) begin
        n_checks++; if ({o_last, o_fill, o_a} !== e_word)
          $display("FAIL soak%0d_word c=%0d: last %b fill %0d a %h want %b %0d %h", d, c, o_last, o_fill, o_a, e_word[13], e_word[12:9], e_word[8:0]); else n_pass++;
      end
      if (prev_stall) begin
        n_checks++; if (o_a !== prev_a || o_fill !== prev_fill || o_last !== prev_last)
          $display("FAIL soak%0d_stable c=%0d: a %h fill %0d last %b want %h %0d %b", d, c, o_a, o_fill, o_last, prev_a, prev_fill, prev_last); else n_pass++;
      end
      prev_stall = o_valid && !r;
      prev_a = o_a; prev_fill = o_fill; prev_last = o_last;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_partial();
    test_backpressure();
    test_edge();
    test_soak(0);
    test_soak(1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
